// File: rtl/health_alarm_manager_pkg.sv
// Shared definitions for the health alarm manager: event codes, alarm FSM states,
// event record width and the pending-event priority encoder.
package health_alarm_manager_pkg;

  localparam int NUM_EVT = 5;
  localparam int CODE_W  = 3;
  localparam int GLYC_W  = 4;
  localparam int REC_W   = CODE_W + GLYC_W;

  localparam logic [CODE_W-1:0] EVT_FALL     = 3'd0;
  localparam logic [CODE_W-1:0] EVT_PRESSURE = 3'd1;
  localparam logic [CODE_W-1:0] EVT_BLOOD    = 3'd2;
  localparam logic [CODE_W-1:0] EVT_HIGHTEMP = 3'd3;
  localparam logic [CODE_W-1:0] EVT_LOWTEMP  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALARM    = 2'd1,
    ST_SILENCED = 2'd2
  } state_t;

  // Lowest set bit wins, so fall (code 0) always goes out first.
  function automatic logic [CODE_W-1:0] first_pending(input logic [NUM_EVT-1:0] p);
    first_pending = '0;
    for (int i = NUM_EVT - 1; i >= 0; i--) begin
      if (p[i]) first_pending = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/health_alarm_manager_if.sv
// Event record stream toward the transmitter (valid/ready); master is the alarm manager.
interface health_alarm_manager_if;
  import health_alarm_manager_pkg::*;

  logic              eventValid;
  logic              eventReady;
  logic [CODE_W-1:0] eventCode;
  logic [GLYC_W-1:0] eventGlycemic;

  modport master (output eventValid, output eventCode, output eventGlycemic, input eventReady);
  modport slave  (input eventValid, input eventCode, input eventGlycemic, output eventReady);

endinterface

// File: rtl/health_alarm_manager_fifo.sv
// alarm_event_fifo: small synchronous FIFO for event records. The output holds the
// last popped head while empty so downstream fields never glitch to stale slots.
module alarm_event_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] head;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign dout    = empty ? last_q : head;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (!empty)  last_q   <= head;
    end
  end

endmodule

// File: rtl/health_alarm_manager.sv
// Health alarm manager: debounces monitor flags, queues onset records, runs the bedside
// alarm FSM. Define HAM_ESCALATION_EN to build the unacknowledged-alarm escalation timer.
//
//  state       | meaning
//  ST_IDLE     | no active alarm
//  ST_ALARM    | alarm sounding, waiting for ackIn
//  ST_SILENCED | acknowledged, silence timer running down
module health_alarm_manager
  import health_alarm_manager_pkg::*;
#(
  parameter int PERSIST_CYCLES  = 4,
  parameter int SILENCE_CYCLES  = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int ESCALATE_CYCLES = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          presureAbnormality,
  input  logic                          bloodAbnormality,
  input  logic                          highTempAbnormality,
  input  logic                          lowTempAbnormality,
  input  logic                          fallDetected,
  input  logic [GLYC_W-1:0]             glycemicIndex,
  input  logic                          ackIn,
  health_alarm_manager_if.master        evt,
  output logic                          alarm,
  output logic                          overflow,
  output logic [3:0]                    dropCount,
  output logic                          escalate
);

  localparam int CW = $clog2(PERSIST_CYCLES + 1);
  localparam int SW = $clog2(SILENCE_CYCLES + 1);
  localparam logic [CW-1:0] PERSIST_M1 = CW'(PERSIST_CYCLES - 1);

  logic [NUM_EVT-1:0] flags_in;
  logic [CW-1:0]      cnt_q [1:NUM_EVT-1];
  logic [CW-1:0]      cnt_d [1:NUM_EVT-1];
  logic [NUM_EVT-1:0] conf_q, conf_d, onset;
  logic [NUM_EVT-1:0] pending_q, pending_d, push_onehot;
  logic               push_req, pop, fifo_full, fifo_empty, drop;
  logic [CODE_W-1:0]  push_code;
  logic [REC_W-1:0]   fifo_dout;
  logic               overflow_q, overflow_d;
  logic [3:0]         drop_cnt_q, drop_cnt_d;
  state_t             state_q, state_d;
  logic [SW-1:0]      sil_cnt_q, sil_cnt_d;

  assign flags_in = {lowTempAbnormality, highTempAbnormality, bloodAbnormality,
                     presureAbnormality, fallDetected};

  // Counters saturate at PERSIST_CYCLES-1; the next high sample confirms.
  always_comb begin
    conf_d[EVT_FALL] = fallDetected;
    for (int i = 1; i < NUM_EVT; i++) begin
      cnt_d[i]  = '0;
      conf_d[i] = flags_in[i] && (cnt_q[i] >= PERSIST_M1);
      if (flags_in[i]) cnt_d[i] = (cnt_q[i] == PERSIST_M1) ? cnt_q[i] : cnt_q[i] + CW'(1);
    end
  end

  assign onset       = conf_d & ~conf_q;
  assign push_req    = |pending_q;
  assign push_code   = first_pending(pending_q);
  assign push_onehot = push_req ? (NUM_EVT'(1) << push_code) : '0;
  assign pending_d   = (pending_q & ~push_onehot) | onset;
  assign pop         = !fifo_empty && evt.eventReady;
  assign drop        = push_req && fifo_full && !pop;
  assign overflow_d  = overflow_q | drop;
  assign drop_cnt_d  = (drop && drop_cnt_q != 4'hF) ? drop_cnt_q + 4'd1 : drop_cnt_q;

  alarm_event_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   ({push_code, glycemicIndex}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign evt.eventValid    = !fifo_empty;
  assign evt.eventCode     = fifo_dout[REC_W-1:GLYC_W];
  assign evt.eventGlycemic = fifo_dout[GLYC_W-1:0];

  always_comb begin
    state_d   = state_q;
    sil_cnt_d = sil_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|onset) state_d = ST_ALARM;
      end
      ST_ALARM: begin
        if (ackIn && !onset[EVT_FALL]) begin
          state_d   = ST_SILENCED;
          sil_cnt_d = SW'(SILENCE_CYCLES);
        end
      end
      ST_SILENCED: begin
        if (onset[EVT_FALL]) begin
          state_d = ST_ALARM;
        end else if (sil_cnt_q == SW'(1)) begin
          state_d = (|conf_q) ? ST_ALARM : ST_IDLE;
        end else begin
          sil_cnt_d = sil_cnt_q - SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_EVT; i++) cnt_q[i] <= '0;
      conf_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      state_q    <= ST_IDLE;
      sil_cnt_q  <= '0;
    end else begin
      for (int i = 1; i < NUM_EVT; i++) cnt_q[i] <= cnt_d[i];
      conf_q     <= conf_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      sil_cnt_q  <= sil_cnt_d;
    end
  end

  assign alarm     = (state_q == ST_ALARM);
  assign overflow  = overflow_q;
  assign dropCount = drop_cnt_q;

`ifdef HAM_ESCALATION_EN
  localparam int EW = $clog2(ESCALATE_CYCLES + 1);

  logic [EW-1:0] esc_cnt_q, esc_cnt_d;
  logic          escalate_q, escalate_d;

  // Down-counter reloads whenever we are outside ALARM; terminal count raises escalate.
  always_comb begin
    esc_cnt_d  = EW'(ESCALATE_CYCLES);
    escalate_d = escalate_q;
    if (state_q == ST_ALARM) begin
      esc_cnt_d = (esc_cnt_q != '0) ? esc_cnt_q - EW'(1) : esc_cnt_q;
      if (state_d == ST_SILENCED)   escalate_d = 1'b0;
      else if (esc_cnt_q == EW'(1)) escalate_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esc_cnt_q  <= EW'(ESCALATE_CYCLES);
      escalate_q <= 1'b0;
    end else begin
      esc_cnt_q  <= esc_cnt_d;
      escalate_q <= escalate_d;
    end
  end

  assign escalate = escalate_q;
`else
  assign escalate = 1'b0;
`endif

endmodule
